vga_timing: RTL

// - Raster timing generator and pixel output stage for the pong display path.
// - Scans PIXEL_H/PIXEL_V to the game engine and takes back its registered PIXEL.
// - Drives HS/VS and blanked 1-bit RGB to the VGA pins; sync is delayed so pins stay aligned.
// - Default mode 800x600@72Hz from the 50 MHz VGA_CLOCK (1 pixel per clock).

---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_timing.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA raster path: display modes, counter width and
// the bundle of stage-0 timing flags carried down the delay line.
package vga_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 3;

    // 800x600 @ 72 Hz, 50 MHz pixel clock (default mode)
    localparam int H_VISIBLE_800 = 800;
    localparam int H_FRONT_800   = 56;
    localparam int H_SYNC_800    = 120;
    localparam int H_BACK_800    = 64;
    localparam int V_VISIBLE_600 = 600;
    localparam int V_FRONT_600   = 37;
    localparam int V_SYNC_600    = 6;
    localparam int V_BACK_600    = 23;

    localparam int H_TOTAL_800 = H_VISIBLE_800 + H_FRONT_800 + H_SYNC_800 + H_BACK_800;
    localparam int V_TOTAL_600 = V_VISIBLE_600 + V_FRONT_600 + V_SYNC_600 + V_BACK_600;
    localparam int H_SYNC_START_800 = H_VISIBLE_800 + H_FRONT_800;
    localparam int H_SYNC_END_800   = H_SYNC_START_800 + H_SYNC_800;
    localparam int V_SYNC_START_600 = V_VISIBLE_600 + V_FRONT_600;
    localparam int V_SYNC_END_600   = V_SYNC_START_600 + V_SYNC_600;

    // 640x480 @ 60 Hz alternative (needs a 25.175 MHz pixel clock, sync active-low)
    localparam int H_VISIBLE_640 = 640;
    localparam int H_FRONT_640   = 16;
    localparam int H_SYNC_640    = 96;
    localparam int H_BACK_640    = 48;
    localparam int V_VISIBLE_480 = 480;
    localparam int V_FRONT_480   = 10;
    localparam int V_SYNC_480    = 2;
    localparam int V_BACK_480    = 33;

    localparam int H_TOTAL_640 = H_VISIBLE_640 + H_FRONT_640 + H_SYNC_640 + H_BACK_640;
    localparam int V_TOTAL_480 = V_VISIBLE_480 + V_FRONT_480 + V_SYNC_480 + V_BACK_480;
    localparam int H_SYNC_START_640 = H_VISIBLE_640 + H_FRONT_640;
    localparam int H_SYNC_END_640   = H_SYNC_START_640 + H_SYNC_640;
    localparam int V_SYNC_START_480 = V_VISIBLE_480 + V_FRONT_480;
    localparam int V_SYNC_END_480   = V_SYNC_START_480 + V_SYNC_480;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } timing_t;

    // Half-open window test lo <= c < hi on the 11-bit counter
    function automatic logic in_window(logic [CNT_W-1:0] c, int lo, int hi);
        return (c >= CNT_W'(lo)) && (c < CNT_W'(hi));
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Reset-clearable shift register; delays the raster flags so they meet the
// engine's registered pixel at the output stage.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             VGA_CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Raster counters, stage-0 sync/active decode and the registered pin stage
// that blanks the engine's colour outside the visible area.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE     = H_VISIBLE_800,
    parameter int   H_FRONT       = H_FRONT_800,
    parameter int   H_SYNC        = H_SYNC_800,
    parameter int   H_BACK        = H_BACK_800,
    parameter int   V_VISIBLE     = V_VISIBLE_600,
    parameter int   V_FRONT       = V_FRONT_600,
    parameter int   V_SYNC        = V_SYNC_600,
    parameter int   V_BACK        = V_BACK_600,
    parameter logic SYNC_ACTIVE   = 1'b1,
    parameter int   PIXEL_LATENCY = 1
) (
    input  logic        VGA_CLOCK,
    input  logic        RESET,
    input  logic [2:0]  PIXEL,
    output logic [10:0] PIXEL_H,
    output logic [10:0] PIXEL_V,
    output logic        ACTIVE,
    output logic        FRAME_START,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    timing_t stage0;
    timing_t delayed;

    always_comb begin
        stage0.act = in_window(h_cnt_q, 0, H_VISIBLE) && in_window(v_cnt_q, 0, V_VISIBLE);
        stage0.hs  = in_window(h_cnt_q, H_SYNC_START, H_SYNC_END);
        stage0.vs  = in_window(v_cnt_q, V_SYNC_START, V_SYNC_END);
    end

    vga_delay_line #(
        .WIDTH(3),
        .DEPTH(PIXEL_LATENCY)
    ) u_delay (
        .VGA_CLOCK(VGA_CLOCK),
        .RESET    (RESET),
        .din      (stage0),
        .dout     (delayed)
    );

    // PIXEL only reaches the pins through the act mux, so X during blank is masked
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    always_comb begin
        rgb_d = delayed.act ? PIXEL : '0;
        hs_d  = delayed.hs ^ ~SYNC_ACTIVE;
        vs_d  = delayed.vs ^ ~SYNC_ACTIVE;
    end

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            rgb_q <= '0;
            hs_q  <= ~SYNC_ACTIVE;
            vs_q  <= ~SYNC_ACTIVE;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign PIXEL_H     = h_cnt_q;
    assign PIXEL_V     = v_cnt_q;
    assign ACTIVE      = stage0.act;
    assign FRAME_START = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign VGA_R       = rgb_q[2];
    assign VGA_G       = rgb_q[1];
    assign VGA_B       = rgb_q[0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;

endmodule
